// File: rtl/cpu_control_unit.sv
// Fetch/decode/control stage of the 8-bit CPU: PC, instruction register and a two-state FETCH/EXEC sequencer.
// Optional feature macro CTRL_BEQ_EN: when defined, opcode 0x07 is BEQ; otherwise it is an illegal-opcode NOP.
module cpu_control_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] imem_instr_i,
  input  logic        imem_busy_i,
  input  logic        zero_i,
  output logic [31:0] pc_o,
  output logic        imem_read_o,
  output logic        write_o,
  output logic [2:0]  inaddress_o,
  output logic [2:0]  out1address_o,
  output logic [2:0]  out2address_o,
  output logic [7:0]  immediate_o,
  output logic        imm_sel_o,
  output logic        neg_sel_o,
  output logic [2:0]  aluop_o,
  output logic        illegal_o
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic [7:0]  op;
  logic [7:0]  offset;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        take_branch;

  assign op            = ir_q[31:24];
  assign offset        = ir_q[23:16];
  assign pc_plus4      = pc_q + 32'd4;
  // Offset counts words, so it is sign-extended and scaled by 4 before adding.
  assign branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
      pc_q    <= 32'd0;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    take_branch   = 1'b0;
    imem_read_o   = 1'b0;
    write_o       = 1'b0;
    inaddress_o   = 3'd0;
    out1address_o = 3'd0;
    out2address_o = 3'd0;
    immediate_o   = 8'd0;
    imm_sel_o     = 1'b0;
    neg_sel_o     = 1'b0;
    aluop_o       = ALU_FWD;
    illegal_o     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_read_o = 1'b1;
        if (!imem_busy_i) begin
          ir_d    = imem_instr_i;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        inaddress_o   = ir_q[18:16];
        out1address_o = ir_q[10:8];
        out2address_o = ir_q[2:0];
        immediate_o   = ir_q[7:0];

        case (op)
          OP_LOADI: begin
            write_o   = 1'b1;
            imm_sel_o = 1'b1;
          end
          OP_MOV: write_o = 1'b1;
          OP_ADD: begin
            write_o = 1'b1;
            aluop_o = ALU_ADD;
          end
          OP_SUB: begin
            write_o   = 1'b1;
            aluop_o   = ALU_ADD;
            neg_sel_o = 1'b1;
          end
          OP_AND: begin
            write_o = 1'b1;
            aluop_o = ALU_AND;
          end
          OP_OR: begin
            write_o = 1'b1;
            aluop_o = ALU_OR;
          end
          OP_J: take_branch = 1'b1;
`ifdef CTRL_BEQ_EN
          OP_BEQ: begin
            aluop_o     = ALU_ADD;
            neg_sel_o   = 1'b1;
            take_branch = zero_i;
          end
`endif
          default: illegal_o = 1'b1;
        endcase

        pc_d    = take_branch ? branch_target : pc_plus4;
        state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus a randomized program
// checked against an instruction-level reference model of PC and decode behaviour.
module tb_cpu_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_instr;
  logic        imem_busy;
  logic        zero;
  logic [31:0] pc;
  logic        imem_read;
  logic        write;
  logic [2:0]  inaddress;
  logic [2:0]  out1address;
  logic [2:0]  out2address;
  logic [7:0]  immediate;
  logic        imm_sel;
  logic        neg_sel;
  logic [2:0]  aluop;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pc_m;

`ifdef CTRL_BEQ_EN
  localparam bit BEQ_EN = 1'b1;
`else
  localparam bit BEQ_EN = 1'b0;
`endif

  cpu_control_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_instr_i (imem_instr),
    .imem_busy_i  (imem_busy),
    .zero_i       (zero),
    .pc_o         (pc),
    .imem_read_o  (imem_read),
    .write_o      (write),
    .inaddress_o  (inaddress),
    .out1address_o(out1address),
    .out2address_o(out2address),
    .immediate_o  (immediate),
    .imm_sel_o    (imm_sel),
    .neg_sel_o    (neg_sel),
    .aluop_o      (aluop),
    .illegal_o    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle {write, inaddr, out1, out2, imm, imm_sel, neg_sel, aluop, illegal}.
  function automatic logic [23:0] ctrl_now();
    return {write, inaddress, out1address, out2address, immediate, imm_sel, neg_sel, aluop, illegal};
  endfunction

  function automatic logic [23:0] exp_ctrl(input logic [31:0] instr);
    logic [7:0] op;
    logic       is_beq;
    logic       w, isel, nsel, ill;
    logic [2:0] alu;
    op     = instr[31:24];
    is_beq = BEQ_EN && (op == 8'h07);
    w      = (op <= 8'h05);
    isel   = (op == 8'h00);
    nsel   = (op == 8'h03) || is_beq;
    if (op == 8'h02 || op == 8'h03 || is_beq) alu = 3'd1;
    else if (op == 8'h04) alu = 3'd2;
    else if (op == 8'h05) alu = 3'd3;
    else alu = 3'd0;
    ill = (op > 8'h07) || (op == 8'h07 && !BEQ_EN);
    return {w, instr[18:16], instr[10:8], instr[2:0], instr[7:0], isel, nsel, alu, ill};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [31:0] instr, input logic z);
    logic [7:0]  op;
    logic [31:0] words;
    logic        taken;
    op    = instr[31:24];
    taken = (op == 8'h06) || (BEQ_EN && op == 8'h07 && z);
    words = {{24{instr[23]}}, instr[23:16]};
    return cur + 32'd4 + (taken ? words * 32'd4 : 32'd0);
  endfunction

  // Runs one instruction from FETCH (entered ~1ns after a rising edge) through EXEC.
  task automatic run_instr(input logic [31:0] instr, input int nbusy, input logic z_exec, input string tag);
    for (int i = 0; i <= nbusy; i++) begin
      imem_busy  = (i < nbusy);
      imem_instr = (i < nbusy) ? $urandom : instr;
      zero       = 1'($urandom);
      #4;
      n_checks++;
      if ({pc, imem_read, ctrl_now()} !== {pc_m, 1'b1, 24'd0}) begin
        n_fail++;
        $display("FAIL %s fetch%0d: pc=%h rd=%b ctrl=%h, want pc=%h rd=1 ctrl=0",
                 tag, i, pc, imem_read, ctrl_now(), pc_m);
      end
      @(posedge clk); #1;
    end
    imem_busy  = 1'($urandom);
    imem_instr = $urandom;
    zero       = z_exec;
    #4;
    n_checks++;
    if ({pc, imem_read, ctrl_now()} !== {pc_m, 1'b0, exp_ctrl(instr)}) begin
      n_fail++;
      $display("FAIL %s exec: pc=%h rd=%b ctrl=%h, want pc=%h rd=0 ctrl=%h",
               tag, pc, imem_read, ctrl_now(), pc_m, exp_ctrl(instr));
    end
    pc_m = next_pc(pc_m, instr, z_exec);
    @(posedge clk); #1;
    n_checks++;
    if ({pc, imem_read} !== {pc_m, 1'b1}) begin
      n_fail++;
      $display("FAIL %s next_pc: pc=%h rd=%b, want pc=%h rd=1", tag, pc, imem_read, pc_m);
    end
  endtask

  task automatic do_reset();
    imem_busy = 1'b1;
    rst_n     = 1'b0;
    pc_m      = 32'd0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    imem_busy  = 1'b0;
    imem_instr = 32'h0004_0005;
    zero       = 1'b1;
    #3;
    n_checks++;
    if ({pc, imem_read, ctrl_now()} !== {32'd0, 1'b1, 24'd0}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h rd=%b ctrl=%h, want pc=0 rd=1 ctrl=0", pc, imem_read, ctrl_now());
    end
    @(posedge clk); #1;
    n_checks++;
    if ({pc, imem_read, write} !== {32'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: pc=%h rd=%b wr=%b, want 0/1/0", pc, imem_read, write);
    end
    do_reset();
  endtask

  task automatic test_alu_ops();
    run_instr(32'h0004_0005, 0, 1'b0, "loadi");
    n_checks++;
    if (pc !== 32'h4) begin
      n_fail++;
      $display("FAIL loadi_pc: pc=%h, want 00000004", pc);
    end
    run_instr(32'h0302_0103, 0, 1'b1, "sub");
    run_instr(32'h0205_0607, 1, 1'b0, "add");
    run_instr(32'h0401_0203, 0, 1'b0, "and");
    run_instr(32'h0507_0001, 0, 1'b0, "or");
    n_checks++;
    if (pc !== 32'h14) begin
      n_fail++;
      $display("FAIL alu_seq_pc: pc=%h, want 00000014", pc);
    end
  endtask

  task automatic test_jump_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) run_instr(32'h0100_0000 | 32'($urandom_range(0, 16'hFFFF)), 0, 1'b0, "mov");
    run_instr(32'h06FC_0000, 0, 1'b0, "j_back");
    n_checks++;
    if (pc !== 32'h4) begin
      n_fail++;
      $display("FAIL j_back_pc: pc=%h, want 00000004", pc);
    end
    run_instr(32'h06FE_0000, 0, 1'b1, "j_neg");
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++;
      $display("FAIL j_neg_pc: pc=%h, want 00000000", pc);
    end
    run_instr(32'h06FE_0000, 0, 1'b0, "j_under");
    run_instr(32'h0201_0203, 0, 1'b0, "add_wrap");
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h, want 00000000", pc);
    end
  endtask

  task automatic test_beq();
    logic [31:0] want;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      run_instr(32'h0200_0000, 0, 1'b0, "add_a");
      run_instr(32'h0200_0000, 0, 1'b0, "add_b");
      run_instr(32'h0702_0102, 0, 1'(z), "beq");
      want = (BEQ_EN && z == 1) ? 32'h14 : 32'h0C;
      n_checks++;
      if (pc !== want) begin
        n_fail++;
        $display("FAIL beq_pc_z%0d: pc=%h, want %h", z, pc, want);
      end
    end
  endtask

  task automatic test_busy();
    run_instr(32'h0203_0405, 3, 1'b0, "busy3");
    run_instr(32'h0811_2233, 2, 1'b1, "illegal");
  endtask

  task automatic test_reset_mid_exec();
    imem_busy  = 1'b0;
    imem_instr = 32'h0206_0102;
    @(posedge clk); #1;
    imem_instr = $urandom;
    #2;
    n_checks++;
    if (write !== 1'b1) begin
      n_fail++;
      $display("FAIL midexec_pre: write=%b, want 1", write);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pc, imem_read, ctrl_now()} !== {32'd0, 1'b1, 24'd0}) begin
      n_fail++;
      $display("FAIL midexec_reset: pc=%h rd=%b ctrl=%h, want pc=0 rd=1 ctrl=0", pc, imem_read, ctrl_now());
    end
    @(posedge clk); #1;
    n_checks++;
    if ({pc, write} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midexec_edge: pc=%h write=%b, want 0/0", pc, write);
    end
    imem_busy = 1'b1;
    pc_m      = 32'd0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random_program();
    logic [31:0] instr;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      instr = {8'($urandom_range(0, 9)), 24'($urandom)};
      run_instr(instr, int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_jump_wrap();
    test_beq();
    test_busy();
    test_reset_mid_exec();
    test_random_program();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
